// File: rtl/rotating_xbar_sched_if.sv
// Stream handshake bundle for rotating_xbar_sched: lane input side and rotated output side.
interface rotating_xbar_sched_if #(
  parameter int unsigned NUM_DATA   = 4,
  parameter int unsigned DATA_WIDTH = 4
);

  logic [NUM_DATA-1:0][DATA_WIDTH-1:0] in_data_i;
  logic                                in_valid_i;
  logic                                in_ready_o;
  logic [NUM_DATA-1:0][DATA_WIDTH-1:0] out_data_o;
  logic [$clog2(NUM_DATA)-1:0]         out_sel_o;
  logic                                out_valid_o;
  logic                                out_ready_i;

  // Producer/consumer side
  modport master (
    output in_data_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_data_o, out_sel_o, out_valid_o
  );

  // Scheduler side
  modport slave (
    input  in_data_i, in_valid_i, out_ready_i,
    output in_ready_o, out_data_o, out_sel_o, out_valid_o
  );

endinterface

// File: rtl/rotating_xbar_sched.sv
// Registered, handshaked lane rotator. Output lane i carries input lane (ptr+i) mod NUM_DATA;
// the pointer steps once every ROT_PERIOD accepted beats.
module rotating_xbar_sched #(
  parameter int unsigned NUM_DATA   = 4,
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ROT_PERIOD = 1
) (
  input  logic                        clk_i,
  input  logic                        arst_i,
  input  logic                        cfg_en_i,
  input  logic                        cfg_load_i,
  input  logic [$clog2(NUM_DATA)-1:0] cfg_ptr_i,
  output logic                        busy_o,
  rotating_xbar_sched_if.slave        bus
);

  localparam int unsigned PW = $clog2(NUM_DATA);
  localparam int unsigned CW = (ROT_PERIOD > 1) ? $clog2(ROT_PERIOD) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_DATA - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ROT_PERIOD - 1);
  localparam logic [PW:0]   NUM_EXT  = (PW + 1)'(NUM_DATA);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                              state_q, state_d;
  logic [PW-1:0]                       ptr_q;
  logic [CW-1:0]                       cnt_q;
  logic                                valid_q;
  logic [NUM_DATA-1:0][DATA_WIDTH-1:0] data_q;
  logic [PW-1:0]                       sel_q;
  logic [NUM_DATA-1:0][DATA_WIDTH-1:0] rot_c;
  logic                                ready_c;
  logic                                accept_c;
  logic                                pop_c;

  // Crossbar: each output lane picks input lane (ptr+i) wrapped by one conditional subtract
  for (genvar g = 0; g < NUM_DATA; g++) begin : g_rot
    logic [PW:0] sum;
    assign sum      = {1'b0, ptr_q} + (PW + 1)'(g);
    assign rot_c[g] = bus.in_data_i[(sum >= NUM_EXT) ? PW'(sum - NUM_EXT) : sum[PW-1:0]];
  end

  // Next-state and input-ready decode
  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_en_i) state_d = RUN;
      end
      RUN: begin
        ready_c = cfg_en_i & (~valid_q | bus.out_ready_i);
        if (!cfg_en_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!valid_q || bus.out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept_c = bus.in_valid_i & ready_c;
  assign pop_c    = valid_q & bus.out_ready_i;

  // State register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Pointer, beat counter and output holding register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      if (state_q == IDLE && cfg_load_i) begin
        ptr_q <= cfg_ptr_i;
        cnt_q <= '0;
      end
      if (accept_c) begin
        data_q  <= rot_c;
        sel_q   <= ptr_q;
        valid_q <= 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_q <= '0;
          ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else if (pop_c) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready_o  = ready_c;
  assign bus.out_data_o  = data_q;
  assign bus.out_sel_o   = sel_q;
  assign bus.out_valid_o = valid_q;
  assign busy_o          = (state_q != IDLE) | valid_q;

endmodule

// File: tb/tb_rotating_xbar_sched.sv
// Bench for rotating_xbar_sched: three instances (N=4/P=1, N=4/P=3, N=3/P=1) share one stimulus
// stream and are checked against a transaction-level model.
module tb_rotating_xbar_sched;

  logic        clk = 1'b0;
  logic        arst;
  logic        en, load;
  logic [1:0]  lptr;
  logic [15:0] in_data;
  logic        in_valid, out_ready;
  logic        busy0, busy1, busy2;

  always #5 clk = ~clk;

  rotating_xbar_sched_if #(.NUM_DATA(4), .DATA_WIDTH(4)) if0 ();
  rotating_xbar_sched_if #(.NUM_DATA(4), .DATA_WIDTH(4)) if1 ();
  rotating_xbar_sched_if #(.NUM_DATA(3), .DATA_WIDTH(4)) if2 ();

  assign if0.in_data_i  = in_data;
  assign if1.in_data_i  = in_data;
  assign if2.in_data_i  = in_data[11:0];
  assign if0.in_valid_i = in_valid;
  assign if1.in_valid_i = in_valid;
  assign if2.in_valid_i = in_valid;
  assign if0.out_ready_i = out_ready;
  assign if1.out_ready_i = out_ready;
  assign if2.out_ready_i = out_ready;

  rotating_xbar_sched #(.NUM_DATA(4), .DATA_WIDTH(4), .ROT_PERIOD(1)) dut0 (
    .clk_i(clk), .arst_i(arst), .cfg_en_i(en), .cfg_load_i(load), .cfg_ptr_i(lptr),
    .busy_o(busy0), .bus(if0));
  rotating_xbar_sched #(.NUM_DATA(4), .DATA_WIDTH(4), .ROT_PERIOD(3)) dut1 (
    .clk_i(clk), .arst_i(arst), .cfg_en_i(en), .cfg_load_i(load), .cfg_ptr_i(lptr),
    .busy_o(busy1), .bus(if1));
  rotating_xbar_sched #(.NUM_DATA(3), .DATA_WIDTH(4), .ROT_PERIOD(1)) dut2 (
    .clk_i(clk), .arst_i(arst), .cfg_en_i(en), .cfg_load_i(load), .cfg_ptr_i(lptr),
    .busy_o(busy2), .bus(if2));

  logic [15:0] o_data  [3];
  logic [1:0]  o_sel   [3];
  logic        o_valid [3];
  logic        o_ready [3];
  logic        o_busy  [3];

  assign o_data[0]  = if0.out_data_o;
  assign o_data[1]  = if1.out_data_o;
  assign o_data[2]  = {4'h0, if2.out_data_o};
  assign o_sel[0]   = if0.out_sel_o;
  assign o_sel[1]   = if1.out_sel_o;
  assign o_sel[2]   = if2.out_sel_o;
  assign o_valid[0] = if0.out_valid_o;
  assign o_valid[1] = if1.out_valid_o;
  assign o_valid[2] = if2.out_valid_o;
  assign o_ready[0] = if0.in_ready_o;
  assign o_ready[1] = if1.in_ready_o;
  assign o_ready[2] = if2.in_ready_o;
  assign o_busy[0]  = busy0;
  assign o_busy[1]  = busy1;
  assign o_busy[2]  = busy2;

  // Reference model: pointer = (base + accepts_since_load / P) mod N
  int          m_mode  [3];   // 0 idle, 1 run, 2 drain
  int          m_base  [3];
  int          m_k     [3];
  bit          m_valid [3];
  logic [15:0] m_data  [3];
  int          m_sel   [3];

  int n_tests = 0;
  int n_fail  = 0;

  int exp_rot   [3][7] = '{'{0, 1, 2, 3, 0, 1, 2}, '{0, 0, 0, 1, 1, 1, 2}, '{0, 1, 2, 0, 1, 2, 0}};
  int exp_load  [3][4] = '{'{2, 3, 0, 1}, '{2, 2, 2, 3}, '{2, 0, 1, 2}};
  int exp_drain [3]    = '{1, 0, 1};

  function automatic int cfg_n(input int d);
    return (d == 2) ? 3 : 4;
  endfunction

  function automatic int cfg_p(input int d);
    return (d == 1) ? 3 : 1;
  endfunction

  function automatic logic [15:0] rotate(input logic [15:0] v, input int p, input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*4 +: 4] = v[((p + i) % n)*4 +: 4];
    return r;
  endfunction

  function automatic bit m_ready(input int d);
    return (m_mode[d] == 1) && en && (!m_valid[d] || out_ready);
  endfunction

  function automatic bit m_busy(input int d);
    return (m_mode[d] != 0) || m_valid[d];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_mode[d] = 0; m_base[d] = 0; m_k[d] = 0;
      m_valid[d] = 1'b0; m_data[d] = '0; m_sel[d] = 0;
    end
  endtask

  // Advance the model with the current inputs, then the clock
  task automatic step();
    bit acc, pop, was_valid;
    int ptr;
    for (int d = 0; d < 3; d++) begin
      acc       = m_ready(d) && in_valid;
      was_valid = m_valid[d];
      pop       = was_valid && out_ready;
      ptr       = (m_base[d] + m_k[d] / cfg_p(d)) % cfg_n(d);
      if (acc) begin
        m_data[d]  = rotate(in_data, ptr, cfg_n(d));
        m_sel[d]   = ptr;
        m_valid[d] = 1'b1;
        m_k[d]++;
      end else if (pop) begin
        m_valid[d] = 1'b0;
      end
      case (m_mode[d])
        0: begin
          if (load) begin m_base[d] = int'(lptr); m_k[d] = 0; end
          if (en) m_mode[d] = 1;
        end
        1: if (!en) m_mode[d] = 2;
        default: if (!was_valid || pop) m_mode[d] = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst = 1'b1; en = 1'b0; load = 1'b0; lptr = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #2 arst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (o_valid[d] !== 1'b0 || o_ready[d] !== 1'b0 || o_busy[d] !== 1'b0 ||
          o_sel[d] !== 2'd0 || o_data[d] !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got v%b r%b b%b sel%0d data %h, want all zero",
                 d, o_valid[d], o_ready[d], o_busy[d], o_sel[d], o_data[d]);
      end
    end
    en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_data = 16'($urandom);
      #1;
      for (int d = 0; d < 3; d++) begin
        n_tests++;
        if (o_ready[d] !== m_ready(d) || o_busy[d] !== m_busy(d)) begin
          n_fail++;
          $display("FAIL reset_pre ready/busy dut%0d cyc%0d: got %b/%b want %b/%b",
                   d, c, o_ready[d], o_busy[d], m_ready(d), m_busy(d));
        end
      end
      step();
      for (int d = 0; d < 3; d++) begin
        n_tests++;
        if (o_valid[d] !== m_valid[d] ||
            (m_valid[d] && (o_data[d] !== m_data[d] || o_sel[d] !== 2'(m_sel[d])))) begin
          n_fail++;
          $display("FAIL reset_pre beat dut%0d cyc%0d: got v%b sel%0d %h want v%b sel%0d %h",
                   d, c, o_valid[d], o_sel[d], o_data[d], m_valid[d], m_sel[d], m_data[d]);
        end
      end
    end
    #1 arst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (o_valid[d] !== 1'b0 || o_ready[d] !== 1'b0 || o_busy[d] !== 1'b0 ||
          o_sel[d] !== 2'd0 || o_data[d] !== 16'h0) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: got v%b r%b b%b sel%0d data %h, want all zero",
                 d, o_valid[d], o_ready[d], o_busy[d], o_sel[d], o_data[d]);
      end
    end
    model_reset();
    out_ready = 1'b1;
    @(posedge clk);
    #2 arst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_data = 16'($urandom);
      #1;
      for (int d = 0; d < 3; d++) begin
        n_tests++;
        if (o_ready[d] !== m_ready(d) || o_busy[d] !== m_busy(d)) begin
          n_fail++;
          $display("FAIL reset_post ready/busy dut%0d cyc%0d: got %b/%b want %b/%b",
                   d, c, o_ready[d], o_busy[d], m_ready(d), m_busy(d));
        end
      end
      step();
      for (int d = 0; d < 3; d++) begin
        n_tests++;
        if (o_valid[d] !== m_valid[d] ||
            (m_valid[d] && (o_data[d] !== m_data[d] || o_sel[d] !== 2'(m_sel[d])))) begin
          n_fail++;
          $display("FAIL reset_post beat dut%0d cyc%0d: got v%b sel%0d %h want v%b sel%0d %h",
                   d, c, o_valid[d], o_sel[d], o_data[d], m_valid[d], m_sel[d], m_data[d]);
        end
        if (c == 1) begin
          n_tests++;
          if (o_valid[d] !== 1'b1 || o_sel[d] !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_first_sel dut%0d: got v%b sel%0d want v1 sel0", d, o_valid[d], o_sel[d]);
          end
        end
      end
    end
  endtask

  task automatic test_rotation();
    do_reset();
    en = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 16'h3210;
    for (int c = 0; c < 48; c++) begin
      if (c >= 8) begin
        in_data  = 16'($urandom);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        n_tests++;
        if (o_ready[d] !== m_ready(d) || o_busy[d] !== m_busy(d)) begin
          n_fail++;
          $display("FAIL rotation ready/busy dut%0d cyc%0d: got %b/%b want %b/%b",
                   d, c, o_ready[d], o_busy[d], m_ready(d), m_busy(d));
        end
      end
      step();
      for (int d = 0; d < 3; d++) begin
        n_tests++;
        if (o_valid[d] !== m_valid[d] ||
            (m_valid[d] && (o_data[d] !== m_data[d] || o_sel[d] !== 2'(m_sel[d])))) begin
          n_fail++;
          $display("FAIL rotation beat dut%0d cyc%0d: got v%b sel%0d %h want v%b sel%0d %h",
                   d, c, o_valid[d], o_sel[d], o_data[d], m_valid[d], m_sel[d], m_data[d]);
        end
        if (c >= 1 && c <= 7) begin
          n_tests++;
          if (o_valid[d] !== 1'b1 || o_sel[d] !== 2'(exp_rot[d][c-1])) begin
            n_fail++;
            $display("FAIL rotation_seq dut%0d beat%0d: got v%b sel%0d want v1 sel%0d",
                     d, c - 1, o_valid[d], o_sel[d], exp_rot[d][c-1]);
          end
        end
      end
      if (c == 2) begin
        n_tests++;
        if (o_data[0] !== 16'h0321) begin
          n_fail++;
          $display("FAIL rotation_beat1_data: got %h want 0321", o_data[0]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] sv_data [3];
    logic [1:0]  sv_sel  [3];
    en = 1'b1;
    for (int c = 0; c < 64; c++) begin
      in_data = 16'($urandom);
      if (c <= 3) begin
        in_valid  = 1'b1;
        out_ready = (c == 0 || c == 3);
      end else begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        n_tests++;
        if (o_ready[d] !== m_ready(d) || o_busy[d] !== m_busy(d)) begin
          n_fail++;
          $display("FAIL backpressure ready/busy dut%0d cyc%0d: got %b/%b want %b/%b",
                   d, c, o_ready[d], o_busy[d], m_ready(d), m_busy(d));
        end
        if (c == 1 || c == 2) begin
          n_tests++;
          if (o_ready[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_ready dut%0d cyc%0d: got %b want 0", d, c, o_ready[d]);
          end
        end
      end
      step();
      for (int d = 0; d < 3; d++) begin
        n_tests++;
        if (o_valid[d] !== m_valid[d] ||
            (m_valid[d] && (o_data[d] !== m_data[d] || o_sel[d] !== 2'(m_sel[d])))) begin
          n_fail++;
          $display("FAIL backpressure beat dut%0d cyc%0d: got v%b sel%0d %h want v%b sel%0d %h",
                   d, c, o_valid[d], o_sel[d], o_data[d], m_valid[d], m_sel[d], m_data[d]);
        end
        if (c == 0) begin
          sv_data[d] = o_data[d];
          sv_sel[d]  = o_sel[d];
        end else if (c == 1 || c == 2) begin
          n_tests++;
          if (o_valid[d] !== 1'b1 || o_data[d] !== sv_data[d] || o_sel[d] !== sv_sel[d]) begin
            n_fail++;
            $display("FAIL stall_hold dut%0d cyc%0d: got v%b sel%0d %h want v1 sel%0d %h",
                     d, c, o_valid[d], o_sel[d], o_data[d], sv_sel[d], sv_data[d]);
          end
        end else if (c == 3 && d != 1) begin
          n_tests++;
          if (o_sel[d] !== 2'((int'(sv_sel[d]) + 1) % cfg_n(d))) begin
            n_fail++;
            $display("FAIL stall_resume_sel dut%0d: got %0d want %0d",
                     d, o_sel[d], (int'(sv_sel[d]) + 1) % cfg_n(d));
          end
        end
      end
    end
  endtask

  task automatic test_load();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 70; c++) begin
      in_data = 16'($urandom);
      if (c == 0) begin
        load = 1'b1; lptr = 2'd2; en = 1'b0; in_valid = 1'b0;
      end else if (c <= 2) begin
        load = 1'b0; en = 1'b1; in_valid = 1'b1;
      end else if (c <= 5) begin
        load = 1'b1; lptr = 2'd0;
      end else begin
        en        = ($urandom_range(0, 7) != 0);
        load      = ($urandom_range(0, 3) == 0);
        lptr      = 2'($urandom_range(0, 2));
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        n_tests++;
        if (o_ready[d] !== m_ready(d) || o_busy[d] !== m_busy(d)) begin
          n_fail++;
          $display("FAIL load ready/busy dut%0d cyc%0d: got %b/%b want %b/%b",
                   d, c, o_ready[d], o_busy[d], m_ready(d), m_busy(d));
        end
      end
      step();
      for (int d = 0; d < 3; d++) begin
        n_tests++;
        if (o_valid[d] !== m_valid[d] ||
            (m_valid[d] && (o_data[d] !== m_data[d] || o_sel[d] !== 2'(m_sel[d])))) begin
          n_fail++;
          $display("FAIL load beat dut%0d cyc%0d: got v%b sel%0d %h want v%b sel%0d %h",
                   d, c, o_valid[d], o_sel[d], o_data[d], m_valid[d], m_sel[d], m_data[d]);
        end
        if (c >= 2 && c <= 5) begin
          n_tests++;
          if (o_valid[d] !== 1'b1 || o_sel[d] !== 2'(exp_load[d][c-2])) begin
            n_fail++;
            $display("FAIL load_seq dut%0d beat%0d: got v%b sel%0d want v1 sel%0d",
                     d, c - 2, o_valid[d], o_sel[d], exp_load[d][c-2]);
          end
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_drain();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      in_data   = 16'($urandom);
      en        = !(c >= 2 && c <= 5);
      in_valid  = (c != 0);
      out_ready = (c >= 5);
      #1;
      for (int d = 0; d < 3; d++) begin
        n_tests++;
        if (o_ready[d] !== m_ready(d) || o_busy[d] !== m_busy(d)) begin
          n_fail++;
          $display("FAIL drain ready/busy dut%0d cyc%0d: got %b/%b want %b/%b",
                   d, c, o_ready[d], o_busy[d], m_ready(d), m_busy(d));
        end
        if (c >= 2 && c <= 4) begin
          n_tests++;
          if (o_busy[d] !== 1'b1 || o_ready[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_busy dut%0d cyc%0d: got busy%b ready%b want busy1 ready0",
                     d, c, o_busy[d], o_ready[d]);
          end
        end
      end
      step();
      for (int d = 0; d < 3; d++) begin
        n_tests++;
        if (o_valid[d] !== m_valid[d] ||
            (m_valid[d] && (o_data[d] !== m_data[d] || o_sel[d] !== 2'(m_sel[d])))) begin
          n_fail++;
          $display("FAIL drain beat dut%0d cyc%0d: got v%b sel%0d %h want v%b sel%0d %h",
                   d, c, o_valid[d], o_sel[d], o_data[d], m_valid[d], m_sel[d], m_data[d]);
        end
        if (c == 5) begin
          n_tests++;
          if (o_busy[d] !== 1'b0 || o_valid[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_idle dut%0d: got busy%b valid%b want 0/0", d, o_busy[d], o_valid[d]);
          end
        end
        if (c == 7) begin
          n_tests++;
          if (o_valid[d] !== 1'b1 || o_sel[d] !== 2'(exp_drain[d])) begin
            n_fail++;
            $display("FAIL drain_retain_sel dut%0d: got v%b sel%0d want v1 sel%0d",
                     d, o_valid[d], o_sel[d], exp_drain[d]);
          end
        end
      end
    end
  endtask

  initial begin
    arst = 1'b1; en = 1'b0; load = 1'b0; lptr = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    test_reset();
    test_rotation();
    test_backpressure();
    test_load();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
